fu_issue_router: RTL and testbench



---
 rtl/fu_issue_router.sv | 170 +++++++++++++++++
 tb/tb_fu_issue_router.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_router.sv
// fu_issue_router
// Steers up to ISSUE_WIDTH issued micro-ops per cycle into per-functional-unit
// FIFO queues, so a momentarily busy FU only holds back micro-ops aimed at it.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   flush              drop everything queued and everything presented this cycle
//   in_valid/in_fu_sel/in_payload  per-slot issue request (slot i in field i)
//   in_accept          combinational per-slot acceptance, in program order
//   fu_valid/fu_payload  head of each FU queue (payload reads 0 when empty)
//   fu_ready           FU consumes its queue head this cycle
//   busy_fu            queue full
//   sel_error          one-cycle pulse after a cycle with an out-of-range select
//   stall_cycles       saturating count of cycles with a rejected valid slot
module fu_issue_router #(
  parameter int ISSUE_WIDTH = 2,
  parameter int FU_NUMBER   = 4,
  parameter int FU_SEL_W    = 3,
  parameter int PAYLOAD_W   = 64,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [ISSUE_WIDTH-1:0]           in_valid,
  input  logic [ISSUE_WIDTH*FU_SEL_W-1:0]  in_fu_sel,
  input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] in_payload,
  output logic [ISSUE_WIDTH-1:0]           in_accept,
  output logic [FU_NUMBER-1:0]             fu_valid,
  output logic [FU_NUMBER*PAYLOAD_W-1:0]   fu_payload,
  input  logic [FU_NUMBER-1:0]             fu_ready,
  output logic [FU_NUMBER-1:0]             busy_fu,
  output logic                             sel_error,
  output logic [31:0]                      stall_cycles
);

  // A depth-1 queue still gets a 1-bit pointer; the storage is sized to the
  // pointer range so every pointer value indexes a real entry.
  localparam int PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam int MEM_SIZE = 2 ** PTR_W;

  logic [CNT_W-1:0]     count_reg [FU_NUMBER];
  logic [FU_SEL_W-1:0]  slot_sel  [ISSUE_WIDTH];
  logic [PAYLOAD_W-1:0] slot_payload [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] slot_in_range;
  logic [ISSUE_WIDTH-1:0] accept;
  logic [ISSUE_WIDTH-1:0] sel_oor;
  int                     slot_offset [ISSUE_WIDTH];
  logic                   blocked;

  logic        sel_error_reg;
  logic [31:0] stall_reg;

  // Pointer advance modulo the queue depth.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = (int'(p) + n) % QUEUE_DEPTH;
    return PTR_W'(s);
  endfunction

  // Free entries of the FU named by sel, from the registered count only:
  // a dequeue happening this cycle does not make room for this cycle's issue.
  function automatic int space_of(input logic [FU_SEL_W-1:0] sel);
    int s;
    s = 0;
    for (int f = 0; f < FU_NUMBER; f++) begin
      if (int'(sel) == f) s = QUEUE_DEPTH - int'(count_reg[f]);
    end
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
      assign slot_sel[gi]      = in_fu_sel[gi*FU_SEL_W +: FU_SEL_W];
      assign slot_payload[gi]  = in_payload[gi*PAYLOAD_W +: PAYLOAD_W];
      assign slot_in_range[gi] = int'(slot_sel[gi]) < FU_NUMBER;
    end
  endgenerate

  // In-order acceptance. slot_offset[i] counts lower accepted slots aimed at
  // the same FU; it is both the space test and the slot's write offset past
  // the tail, which keeps same-FU slots in slot order inside the queue.
  always_comb begin
    accept  = '0;
    sel_oor = '0;
    blocked = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++) slot_offset[i] = 0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        if (accept[j] && (slot_sel[j] == slot_sel[i])) slot_offset[i] = slot_offset[i] + 1;
      end
      if (in_valid[i]) begin
        sel_oor[i] = !slot_in_range[i];
        if (!blocked) begin
          if (slot_in_range[i] && (space_of(slot_sel[i]) > slot_offset[i])) accept[i] = 1'b1;
          else blocked = 1'b1;
        end
      end
    end
    if (!rst_n || flush) accept = '0;
  end

  assign in_accept = accept;

  generate
    for (gi = 0; gi < FU_NUMBER; gi++) begin : g_fu
      logic [PAYLOAD_W-1:0] mem [MEM_SIZE];
      logic [PTR_W-1:0]     head_reg;
      logic [PTR_W-1:0]     tail_reg;
      int                   enq_num;
      logic                 deq;

      always_comb begin
        enq_num = 0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          if (accept[i] && (int'(slot_sel[i]) == gi)) enq_num = enq_num + 1;
        end
      end

      // fu_ready against an empty queue is ignored.
      assign deq = (count_reg[gi] != '0) && fu_ready[gi];

      always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          if (accept[i] && (int'(slot_sel[i]) == gi)) begin
            mem[ptr_add(tail_reg, slot_offset[i])] <= slot_payload[i];
          end
        end
      end

      // Reset and flush both empty the queue; accept is already forced low
      // in those cycles so no write lands that matters.
      always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
          count_reg[gi] <= '0;
          head_reg      <= '0;
          tail_reg      <= '0;
        end else begin
          count_reg[gi] <= CNT_W'(int'(count_reg[gi]) + enq_num - int'(deq));
          tail_reg      <= ptr_add(tail_reg, enq_num);
          if (deq) head_reg <= ptr_add(head_reg, 1);
        end
      end

      assign fu_valid[gi] = (count_reg[gi] != '0);
      assign busy_fu[gi]  = (int'(count_reg[gi]) == QUEUE_DEPTH);
      assign fu_payload[gi*PAYLOAD_W +: PAYLOAD_W] = fu_valid[gi] ? mem[head_reg] : '0;
    end
  endgenerate

  // Any valid slot carrying an out-of-range select flags an error, whether or
  // not an earlier slot already blocked it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_error_reg <= 1'b0;
      stall_reg     <= '0;
    end else begin
      sel_error_reg <= !flush && (|sel_oor);
      if (!flush && (|(in_valid & ~accept)) && (stall_reg != 32'hFFFF_FFFF)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  assign sel_error    = sel_error_reg;
  assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_fu_issue_router.sv
// tb_fu_issue_router
// Table-driven scenario vectors, a FIFO wrap sequence and a randomized phase,
// all compared every cycle against a queue-based reference model.
module tb_fu_issue_router;
  localparam int IW = 2;
  localparam int FN = 4;
  localparam int SW = 3;
  localparam int PW = 64;
  localparam int QD = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [IW-1:0]     in_valid;
  logic [IW*SW-1:0]  in_fu_sel;
  logic [IW*PW-1:0]  in_payload;
  logic [IW-1:0]     in_accept;
  logic [FN-1:0]     fu_valid;
  logic [FN*PW-1:0]  fu_payload;
  logic [FN-1:0]     fu_ready;
  logic [FN-1:0]     busy_fu;
  logic              sel_error;
  logic [31:0]       stall_cycles;

  always #5 clk = ~clk;

  fu_issue_router #(
    .ISSUE_WIDTH(IW), .FU_NUMBER(FN), .FU_SEL_W(SW), .PAYLOAD_W(PW), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_fu_sel(in_fu_sel), .in_payload(in_payload),
    .in_accept(in_accept),
    .fu_valid(fu_valid), .fu_payload(fu_payload), .fu_ready(fu_ready),
    .busy_fu(busy_fu), .sel_error(sel_error), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: one plain queue per FU plus the two status values.
  logic [PW-1:0] mq [FN][$];
  logic          m_sel_err = 1'b0;
  logic [31:0]   m_stall = 32'd0;

  function automatic int sel_of(input int i);
    return int'(in_fu_sel[i*SW +: SW]);
  endfunction

  function automatic logic [IW-1:0] model_accept();
    logic [IW-1:0] a;
    int taken [FN];
    bit stop;
    a = '0;
    stop = 1'b0;
    for (int f = 0; f < FN; f++) taken[f] = 0;
    if (!rst_n || flush) return '0;
    for (int i = 0; i < IW; i++) begin
      int s;
      if (!in_valid[i]) continue;
      if (stop) break;
      s = sel_of(i);
      if (s >= FN || (QD - mq[s].size()) <= taken[s]) stop = 1'b1;
      else begin
        a[i] = 1'b1;
        taken[s]++;
      end
    end
    return a;
  endfunction

  task automatic model_update(input logic [IW-1:0] acc);
    if (!rst_n || flush) begin
      for (int f = 0; f < FN; f++) mq[f].delete();
      m_sel_err = 1'b0;
      if (!rst_n) m_stall = 32'd0;
    end else begin
      for (int f = 0; f < FN; f++) begin
        if (mq[f].size() > 0 && fu_ready[f]) void'(mq[f].pop_front());
      end
      for (int i = 0; i < IW; i++) begin
        if (acc[i]) mq[sel_of(i)].push_back(in_payload[i*PW +: PW]);
      end
      m_sel_err = 1'b0;
      for (int i = 0; i < IW; i++) begin
        if (in_valid[i] && sel_of(i) >= FN) m_sel_err = 1'b1;
      end
      if ((in_valid & ~acc) != '0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic compare_outputs(input logic [IW-1:0] exp_acc);
    check("in_accept", in_accept, exp_acc);
    for (int f = 0; f < FN; f++) begin
      check($sformatf("fu_valid[%0d]", f), fu_valid[f], mq[f].size() != 0);
      check($sformatf("busy_fu[%0d]", f), busy_fu[f], mq[f].size() == QD);
      check($sformatf("fu_payload[%0d]", f), fu_payload[f*PW +: PW],
            (mq[f].size() != 0) ? mq[f][0] : 64'd0);
    end
    check("sel_error", sel_error, m_sel_err);
    check("stall_cycles", stall_cycles, m_stall);
  endtask

  // Called with inputs just driven (away from the edge); advances one cycle.
  task automatic step(input bit use_tbl, input logic [IW-1:0] tbl_acc);
    logic [IW-1:0] acc;
    #1;
    acc = model_accept();
    compare_outputs(acc);
    if (use_tbl) check("tbl_accept", in_accept, tbl_acc);
    @(posedge clk);
    model_update(acc);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [2:0]  sel0;
    logic [2:0]  sel1;
    logic [63:0] p0;
    logic [63:0] p1;
    logic [3:0]  ready;
    logic        flush;
    logic [1:0]  exp_acc;
    logic [3:0]  exp_fv;
  } vec_t;

  vec_t tv [11];

  initial begin
    tv[0]  = '{2'b11, 3'd2, 3'd3, 64'hA,  64'hB,  4'b0000, 1'b0, 2'b11, 4'b1100};
    tv[1]  = '{2'b01, 3'd0, 3'd0, 64'h10, 64'h0,  4'b0000, 1'b0, 2'b01, 4'b1101};
    tv[2]  = '{2'b11, 3'd0, 3'd0, 64'h11, 64'h12, 4'b0000, 1'b0, 2'b01, 4'b1101};
    tv[3]  = '{2'b11, 3'd0, 3'd1, 64'h13, 64'h14, 4'b0000, 1'b0, 2'b00, 4'b1101};
    tv[4]  = '{2'b10, 3'd0, 3'd1, 64'h15, 64'h20, 4'b0000, 1'b0, 2'b10, 4'b1111};
    tv[5]  = '{2'b01, 3'd5, 3'd2, 64'h16, 64'h17, 4'b0000, 1'b0, 2'b00, 4'b1111};
    tv[6]  = '{2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  4'b1111, 1'b0, 2'b00, 4'b0001};
    tv[7]  = '{2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  4'b0000, 1'b0, 2'b00, 4'b0001};
    tv[8]  = '{2'b11, 3'd1, 3'd1, 64'h30, 64'h31, 4'b0000, 1'b0, 2'b11, 4'b0011};
    tv[9]  = '{2'b11, 3'd2, 3'd2, 64'h40, 64'h41, 4'b0010, 1'b1, 2'b00, 4'b0000};
    tv[10] = '{2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  4'b1111, 1'b0, 2'b00, 4'b0000};

    // Reset held for two cycles with both slots requesting.
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 2'b11;
    in_fu_sel = {3'd1, 3'd0};
    in_payload = '0;
    fu_ready = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("reset_accept", in_accept, 2'b00);
      @(posedge clk);
      model_update(model_accept());
      @(negedge clk);
    end
    rst_n = 1'b1;
    in_valid = '0;
    #1;
    check("post_reset_fu_valid", fu_valid, 4'b0000);
    check("post_reset_stall", stall_cycles, 32'd0);
    check("post_reset_sel_error", sel_error, 1'b0);
    $display("txn reset released");
    step(1'b0, 2'b00);

    // Scenario table.
    for (int k = 0; k < 11; k++) begin
      in_valid   = tv[k].valid;
      in_fu_sel  = {tv[k].sel1, tv[k].sel0};
      in_payload = {tv[k].p1, tv[k].p0};
      fu_ready   = tv[k].ready;
      flush      = tv[k].flush;
      step(1'b1, tv[k].exp_acc);
      #1;
      check($sformatf("tbl_fu_valid_next[%0d]", k), fu_valid, tv[k].exp_fv);
      $display("txn vec=%0d valid=%b accept_exp=%b fu_valid=%b stall=%0d sel_error=%b",
               k, tv[k].valid, tv[k].exp_acc, fu_valid, stall_cycles, sel_error);
    end
    flush = 1'b0;

    // FIFO wrap on FU0: enqueue then dequeue payloads 1..5.
    for (int k = 1; k <= 5; k++) begin
      in_valid   = 2'b01;
      in_fu_sel  = {3'd0, 3'd0};
      in_payload = {64'd0, 64'(k)};
      fu_ready   = 4'b0000;
      step(1'b1, 2'b01);
      in_valid = 2'b00;
      fu_ready = 4'b0001;
      #1;
      check($sformatf("wrap_payload[%0d]", k), fu_payload[PW-1:0], 64'(k));
      $display("txn wrap k=%0d head=%0h", k, fu_payload[PW-1:0]);
      step(1'b0, 2'b00);
    end

    // Randomized traffic with occasional flush, reset and bad selects.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_valid = IW'($urandom_range(0, 3));
      for (int i = 0; i < IW; i++) begin
        in_fu_sel[i*SW +: SW] = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(4, 7))
                                                            : SW'($urandom_range(0, 3));
        in_payload[i*PW +: PW] = {$urandom, $urandom};
      end
      fu_ready = FN'($urandom_range(0, 15));
      step(1'b0, 2'b00);
    end
    $display("txn random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
